// File: rtl/cpu_types_pkg.sv
// Shared types for the 5-stage core: memory-op codes, pipeline-control FSM states and the per-cycle latch control word.
// The CW_* constants are the complete set of control words the sequencer can drive.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    MEM_NONE = 2'b00,
    MEM_RD   = 2'b01,
    MEM_WR   = 2'b10
  } memop_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DWAIT  = 2'b01,
    HALTED = 2'b10
  } pctrl_state_t;

  typedef logic [4:0] regbits_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } ctrl_word_t;

  localparam ctrl_word_t CW_RESET  = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
                                       ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1, memwb_flush: 1'b1};
  localparam ctrl_word_t CW_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
                                       ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0};
  localparam ctrl_word_t CW_DSTALL = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
                                       ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b1};
  localparam ctrl_word_t CW_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1,
                                       ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b0, memwb_flush: 1'b0};
  localparam ctrl_word_t CW_LDUSE  = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1,
                                       ifid_flush: 1'b0, idex_flush: 1'b1, exmem_flush: 1'b0, memwb_flush: 1'b0};
  localparam ctrl_word_t CW_JUMP   = '{pc_en: 1'b1, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                       ifid_flush: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0};
  localparam ctrl_word_t CW_IMISS  = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                       ifid_flush: 1'b1, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0};
  localparam ctrl_word_t CW_RUN    = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
                                       ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0};

  // A data access holds the pipe until the dcache acknowledges it; dhit with no access is meaningless.
  function automatic logic dmem_pending(input memop_t op, input logic hit);
    return (op != MEM_NONE) && !hit;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers of the instruction in ID.
// Purely combinational; r0 never creates a dependency.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_memread_i,
  input  regbits_t idex_rd_i,
  input  regbits_t ifid_rs_i,
  input  regbits_t ifid_rt_i,
  input  logic     ifid_uses_rt_i,
  output logic     load_use_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match   = (idex_rd_i == ifid_rs_i);
  assign rt_match   = ifid_uses_rt_i && (idex_rd_i == ifid_rt_i);
  assign load_use_o = idex_memread_i && (idex_rd_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/stall sequencer: one combinational enable/flush word per cycle from FSM state + hazard inputs; halt/wait_err sticky.
// PIPE_PERF_EN adds saturating stall_cnt/flush_cnt outputs; without it the control behaviour is unchanged.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 1023,
  parameter int unsigned CNT_W    = 10
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     ihit,
  input  logic     dhit,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_uses_rt,
  input  logic     idex_memread,
  input  regbits_t idex_rd,
  input  logic     ex_br_taken,
  input  logic     id_jump,
  input  memop_t   exmem_mem,
  input  logic     memwb_halt,
  output logic     pc_en,
  output logic     ifid_en,
  output logic     idex_en,
  output logic     exmem_en,
  output logic     memwb_en,
  output logic     ifid_flush,
  output logic     idex_flush,
  output logic     exmem_flush,
  output logic     memwb_flush,
  output logic     halt,
  output logic     wait_err
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  pctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             halt_q, halt_d;
  logic             err_q, err_d;
  logic             load_use;
  logic             dpend;
  ctrl_word_t       cw;

  hazard_detect u_hazard_detect (
    .idex_memread_i (idex_memread),
    .idex_rd_i      (idex_rd),
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .ifid_uses_rt_i (ifid_uses_rt),
    .load_use_o     (load_use)
  );

  assign dpend   = dmem_pending(exmem_mem, dhit);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    cw      = CW_RUN;
    state_d = state_q;
    cnt_d   = '0;
    halt_d  = halt_q;
    err_d   = err_q;

    if (state_q == HALTED) begin
      cw = CW_FREEZE;
    end else if (memwb_halt) begin
      cw      = CW_FREEZE;
      state_d = HALTED;
      halt_d  = 1'b1;
    end else if (dpend) begin
      cw      = CW_DSTALL;
      state_d = DWAIT;
      // Watchdog counts only cycles already spent in DWAIT; it saturates at the limit.
      if (state_q == DWAIT) begin
        cnt_d = (cnt_q == WAIT_LIM) ? cnt_q : cnt_inc;
        if (cnt_inc == WAIT_LIM) begin
          err_d = 1'b1;
        end
      end
    end else begin
      state_d = RUN;
      if (ex_br_taken) begin
        cw = CW_BRANCH;
      end else if (load_use) begin
        cw = CW_LDUSE;
      end else if (id_jump) begin
        cw = CW_JUMP;
      end else if (!ihit) begin
        cw = CW_IMISS;
      end
    end

    if (RST) begin
      cw = CW_RESET;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  assign pc_en       = cw.pc_en;
  assign ifid_en     = cw.ifid_en;
  assign idex_en     = cw.idex_en;
  assign exmem_en    = cw.exmem_en;
  assign memwb_en    = cw.memwb_en;
  assign ifid_flush  = cw.ifid_flush;
  assign idex_flush  = cw.idex_flush;
  assign exmem_flush = cw.exmem_flush;
  assign memwb_flush = cw.memwb_flush;
  assign halt        = halt_q;
  assign wait_err    = err_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic        stall_evt;
  logic        redirect_evt;

  assign stall_evt    = !cw.pc_en && (state_q != HALTED);
  // Only branch and jump flush IF/ID while still advancing the PC; an icache miss flushes with the PC held.
  assign redirect_evt = cw.ifid_flush && cw.pc_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (redirect_evt && (flush_q != '1)) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with WAIT_MAX=8: hand-computed control words checked mid-cycle after each stimulus step.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  logic     CLK;
  logic     RST;
  logic     ihit, dhit, ifid_uses_rt, idex_memread, ex_br_taken, id_jump, memwb_halt;
  regbits_t ifid_rs, ifid_rt, idex_rd;
  memop_t   exmem_mem;
  logic     pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic     ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic     halt, wait_err;
  logic [8:0] cw_obs;

  int passed = 0;
  int total  = 0;

  // Expected words, order {pc,ifid,idex,exmem,memwb en ; ifid,idex,exmem,memwb flush}
  localparam logic [8:0] E_RESET  = 9'b00000_1111;
  localparam logic [8:0] E_RUN    = 9'b11111_0000;
  localparam logic [8:0] E_DSTALL = 9'b00000_0001;
  localparam logic [8:0] E_FREEZE = 9'b00000_0000;
  localparam logic [8:0] E_BRANCH = 9'b10011_1100;
  localparam logic [8:0] E_LDUSE  = 9'b00011_0100;
  localparam logic [8:0] E_JUMP   = 9'b10111_1000;
  localparam logic [8:0] E_IMISS  = 9'b00111_1000;

  pipeline_ctrl #(.WAIT_MAX(8), .CNT_W(10)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .ex_br_taken(ex_br_taken),
    .id_jump(id_jump), .exmem_mem(exmem_mem), .memwb_halt(memwb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt(halt), .wait_err(wait_err)
  );

  assign cw_obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_cw(input string tag, input logic [8:0] exp);
    #1;
    chk(tag, {23'd0, cw_obs}, {23'd0, exp});
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b1; dhit = 1'b0; ifid_uses_rt = 1'b0; idex_memread = 1'b0;
    ex_br_taken = 1'b0; id_jump = 1'b0; memwb_halt = 1'b0;
    ifid_rs = '0; ifid_rt = '0; idex_rd = '0; exmem_mem = MEM_NONE;

    // Reset held for three edges
    tick(); tick(); tick();
    chk_cw("reset_cw", E_RESET);
    chk("reset_halt", {31'd0, halt}, 32'd0);
    chk("reset_werr", {31'd0, wait_err}, 32'd0);
    RST = 1'b0;
    chk_cw("first_run", E_RUN);

    // dcache read miss for 4 cycles, then hit
    tick();
    exmem_mem = MEM_RD; dhit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_cw("dwait_stall", E_DSTALL);
      tick();
    end
    chk("dwait_state", 32'(dut.state_q), 32'(DWAIT));
    dhit = 1'b1;
    chk_cw("dwait_release", E_RUN);
    tick();
    exmem_mem = MEM_NONE;
    chk("dwait_back_run", 32'(dut.state_q), 32'(RUN));
    chk_cw("dhit_no_access", E_RUN);
    dhit = 1'b0;

    // Load-use on rs, then bubble gone; r0 never stalls; rt path gated by uses_rt
    idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs = 5'd5;
    chk_cw("lduse_rs", E_LDUSE);
    tick();
    idex_memread = 1'b0;
    chk_cw("lduse_one_bubble", E_RUN);
    idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0;
    chk_cw("lduse_r0", E_RUN);
    idex_rd = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7; ifid_uses_rt = 1'b1;
    chk_cw("lduse_rt", E_LDUSE);
    ifid_uses_rt = 1'b0;
    chk_cw("lduse_rt_unused", E_RUN);

    // Branch beats load-use and icache miss; jump and miss alone
    ifid_uses_rt = 1'b1; ihit = 1'b0; ex_br_taken = 1'b1;
    chk_cw("branch_prio", E_BRANCH);
    idex_memread = 1'b0; ex_br_taken = 1'b0; id_jump = 1'b1;
    chk_cw("jump_miss", E_JUMP);
    id_jump = 1'b0;
    chk_cw("imiss", E_IMISS);
    ihit = 1'b1;

    // Pending dcache beats branch; branch takes effect once unfrozen
    exmem_mem = MEM_RD; dhit = 1'b0; ex_br_taken = 1'b1;
    chk_cw("dmem_over_branch", E_DSTALL);
    tick();
    dhit = 1'b1;
    chk_cw("branch_after_dhit", E_BRANCH);
    tick();
    exmem_mem = MEM_NONE; dhit = 1'b0; ex_br_taken = 1'b0;

    // Watchdog: 1 entry cycle + 7 DWAIT cycles -> not yet; 8th DWAIT cycle -> sticky error
    exmem_mem = MEM_WR;
    for (int i = 0; i < 8; i++) tick();
    chk("werr_before_limit", {31'd0, wait_err}, 32'd0);
    tick();
    chk("werr_at_limit", {31'd0, wait_err}, 32'd1);
    dhit = 1'b1;
    chk_cw("werr_release", E_RUN);
    tick();
    exmem_mem = MEM_NONE; dhit = 1'b0;
    tick();
    chk("werr_sticky", {31'd0, wait_err}, 32'd1);
    RST = 1'b1;
    tick();
    chk("werr_rst_clear", {31'd0, wait_err}, 32'd0);
    chk_cw("rst_again_cw", E_RESET);
    RST = 1'b0;

    // Reset in the middle of DWAIT
    exmem_mem = MEM_RD;
    tick(); tick(); tick();
    chk("mid_dwait_cnt", 32'(dut.cnt_q), 32'd2);
    RST = 1'b1;
    tick();
    RST = 1'b0; exmem_mem = MEM_NONE;
    chk("mid_rst_state", 32'(dut.state_q), 32'(RUN));
    chk("mid_rst_cnt", 32'(dut.cnt_q), 32'd0);

    // Halt: freeze now, halt flag one cycle later, nothing restarts it but reset
    memwb_halt = 1'b1;
    chk_cw("halt_req_cw", E_FREEZE);
    chk("halt_not_yet", {31'd0, halt}, 32'd0);
    tick();
    memwb_halt = 1'b0; ihit = 1'b1; dhit = 1'b1; exmem_mem = MEM_RD;
    chk("halt_set", {31'd0, halt}, 32'd1);
    chk_cw("halted_cw", E_FREEZE);
    tick();
    ex_br_taken = 1'b1; id_jump = 1'b1;
    chk_cw("halted_hold", E_FREEZE);
    chk("halt_sticky", {31'd0, halt}, 32'd1);
    ex_br_taken = 1'b0; id_jump = 1'b0; exmem_mem = MEM_NONE; dhit = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("halt_rst_clear", {31'd0, halt}, 32'd0);
    chk_cw("run_after_halt", E_RUN);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
